mul_booth_seq: RTL and testbench
================================

Name: mul_booth_seq

Overview:
- Iterative radix-4 Booth multiplier sequencer for the M-extension execute path.
- Accepts a RISC-V MUL/MULH/MULHSU/MULHU request and precomputes the ±A and ±2A multiplicand terms.
- Steps the Booth window over the multiplier, one digit per cycle, and feeds each 3-bit window plus the precomputed terms to the booth partial-product selector.
- Accumulates the selected partial products in carry-save form, does one final carry-propagate add, and returns the 32-bit result over a valid/ready handshake.

Parameters:
- XLEN, 32, operand and result width.
- EXT_W, XLEN+2, extended operand width (33-bit signed value padded to an even length).
- NDIG, EXT_W/2 (17), number of radix-4 Booth digits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_rs1  in  XLEN  multiplicand A.
- req_rs2  in  XLEN  multiplier B.
- flush  in  1  pipeline kill; aborts any operation in flight.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  XLEN  product (low half for MUL, high half otherwise).

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, resp_valid=0, resp_data=0, counter=0, accumulators=0. req_ready=1 from the cycle after rst deasserts.
- States: IDLE -> CALC -> FINAL -> DONE -> IDLE.
- IDLE:
  - req_valid & req_ready latches the operands; next state is CALC with cnt=0.
  - A is sign-extended to EXT_W for MUL/MULH/MULHSU and zero-extended for MULHU.
  - B is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
  - Registers num_data_width=A, num_minus=-A, num_double=A<<1, num_double_minus=-(A<<1), all EXT_W bits, two's complement, truncated.
  - mreg = {B_ext, 1'b0}, i.e. EXT_W+1 bits with an implicit b[-1]=0.
  - sum_acc=0, carry_acc=0, both 2*XLEN bits.
- CALC:
  - Booth window y = mreg[2:0] each cycle.
  - Partial product is sign-extended and shifted left by 2*cnt, truncated to 2*XLEN.
  - Carry-save add: {sum_acc, carry_acc} <= CSA(sum_acc, carry_acc<<1, pp). Carry bit 2*XLEN-1 is discarded.
  - Then mreg >>= 2 and cnt++. When cnt==NDIG-1, next state is FINAL.
- FINAL: prod = sum_acc + (carry_acc<<1), modulo 2^(2*XLEN). resp_data <= req_op==MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]. resp_valid <= 1. Next state is DONE.
- DONE: resp_valid and resp_data hold stable until resp_ready. On the handshake: resp_valid <= 0, next state is IDLE.
- Latency and throughput:
  - Fixed latency, no early termination.
  - Acceptance in cycle 0 gives resp_valid high in cycle NDIG+2 (cycle 19).
  - Throughput is one request per NDIG+3 cycles minimum; no acceptance while busy.
- Operand edge cases: the 0x80000000 and 0xFFFFFFFF operands need no special casing; EXT_W extension guarantees -2A is representable.
- flush:
  - In any state, the next state is IDLE and resp_valid <= 0. Datapath registers need not clear.
  - flush has priority over req_valid and resp_ready in the same cycle; a request offered with flush high is not accepted.
- rst mid-operation has the same effect as flush plus clearing resp_data.
- req_ready is combinational from state only; it has no path from req_valid.

Decomposition:
- Package mul_pkg holds:
  - XLEN, EXT_W, NDIG.
  - MUL_OP_MUL/MULH/MULHSU/MULHU encodings.
  - State encodings IDLE/CALC/FINAL/DONE.
- Reuses the existing booth partial-product selector (DATA_WIDTH=EXT_W, BIAS=0) and carry_save_adder (DATA_WIDTH=2*XLEN); shifting is done in this block.
- One natural new sub-module: mul_booth_operand_prep. It is combinational and handles operand extension by op plus ±A/±2A generation; its outputs are registered in this block.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), accepted cycle 0 -> resp_valid at cycle 19, resp_data 0xFFFFFFEB.
- 0xFFFFFFFF × 0xFFFFFFFF -> MUL 0x00000001, MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MUL 0x12345678 × 0x10 -> 0x23456780.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data stable, req_ready=0 throughout. Handshake -> resp_valid=0 and req_ready=1 the next cycle.
- flush in CALC at cnt=8 -> resp_valid never rises, req_ready=1 next cycle. A following MUL 3×5 returns 0x0000000F with full 19-cycle latency.
- rst asserted in DONE with resp_ready=0 -> next cycle resp_valid=0, resp_data=0, req_ready=1. flush and req_valid together in IDLE -> request not accepted.

Source files
------------

// File: rtl/mul_booth_seq_pkg.sv
// Shared constants, opcode encodings and FSM state type for the
// iterative radix-4 Booth multiplier.
package mul_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXT_W = XLEN + 2;
    localparam int unsigned NDIG  = EXT_W / 2;
    localparam int unsigned CNT_W = $clog2(NDIG + 1);

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_booth_seq_if.sv
// Request/response handshake bundle between the execute stage and the
// multiplier. The master drives requests; the slave is the multiplier.
interface mul_booth_seq_if;
    import mul_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [XLEN-1:0]   req_rs1;
    logic [XLEN-1:0]   req_rs2;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/booth.sv
// Radix-4 Booth partial-product selector: picks 0, +-A or +-2A from the
// precomputed multiplicand terms according to a 3-bit Booth window.
module booth #(
    parameter int unsigned DATA_WIDTH = 34,
    parameter int          BIAS       = 0
) (
    input  logic [2:0]            y,
    input  logic [DATA_WIDTH-1:0] num_data_width,
    input  logic [DATA_WIDTH-1:0] num_minus,
    input  logic [DATA_WIDTH-1:0] num_double,
    input  logic [DATA_WIDTH-1:0] num_double_minus,
    output logic [DATA_WIDTH-1:0] pp
);

    logic [DATA_WIDTH-1:0] sel;

    // Booth digit decode: 000/111 -> 0, 001/010 -> +A, 011 -> +2A,
    // 100 -> -2A, 101/110 -> -A
    always_comb begin
        sel = '0;
        unique case (y)
            3'b001, 3'b010: sel = num_data_width;
            3'b011:         sel = num_double;
            3'b100:         sel = num_double_minus;
            3'b101, 3'b110: sel = num_minus;
            default:        sel = '0;
        endcase
        pp = sel + DATA_WIDTH'(BIAS);
    end

endmodule

// File: rtl/carry_save_adder.sv
// Bitwise 3:2 compressor: reduces three operands to a sum and a carry
// vector (carry not yet shifted into its weight position).
module carry_save_adder #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0] carry
);

    // Full-adder per bit position
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/mul_booth_seq_operand_prep.sv
// Operand extension by opcode signedness and generation of the +-A / +-2A
// multiplicand terms. Purely combinational; the caller registers outputs.
module mul_booth_operand_prep
    import mul_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic [EXT_W-1:0] num_data_width,
    output logic [EXT_W-1:0] num_minus,
    output logic [EXT_W-1:0] num_double,
    output logic [EXT_W-1:0] num_double_minus,
    output logic [EXT_W-1:0] b_ext
);

    logic             a_sign;
    logic             b_sign;
    logic [EXT_W-1:0] a_ext;

    // A is signed except for MULHU; B is signed only for MUL/MULH
    always_comb begin
        a_sign           = (op != MUL_OP_MULHU) & rs1[XLEN-1];
        b_sign           = ((op == MUL_OP_MUL) | (op == MUL_OP_MULH)) & rs2[XLEN-1];
        a_ext            = {{(EXT_W-XLEN){a_sign}}, rs1};
        b_ext            = {{(EXT_W-XLEN){b_sign}}, rs2};
        num_data_width   = a_ext;
        num_minus        = -a_ext;
        num_double       = a_ext << 1;
        num_double_minus = -(a_ext << 1);
    end

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle into a
// carry-save accumulator, then a single carry-propagate add.
module mul_booth_seq
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mul_booth_seq_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [EXT_W:0]      mreg_q, mreg_d;
    logic [EXT_W-1:0]    num_data_width_q, num_data_width_d;
    logic [EXT_W-1:0]    num_minus_q, num_minus_d;
    logic [EXT_W-1:0]    num_double_q, num_double_d;
    logic [EXT_W-1:0]    num_double_minus_q, num_double_minus_d;
    logic [2*XLEN-1:0]   sum_acc_q, sum_acc_d;
    logic [2*XLEN-1:0]   carry_acc_q, carry_acc_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;

    logic [EXT_W-1:0]    prep_pos, prep_neg, prep_dbl, prep_dbl_neg, prep_b_ext;
    logic [EXT_W-1:0]    pp;
    logic [2*XLEN-1:0]   pp_shift;
    logic [2*XLEN-1:0]   carry_in;
    logic [2*XLEN-1:0]   csa_sum, csa_carry;
    logic [2*XLEN-1:0]   prod;

    mul_booth_operand_prep u_prep (
        .op               (bus.req_op),
        .rs1              (bus.req_rs1),
        .rs2              (bus.req_rs2),
        .num_data_width   (prep_pos),
        .num_minus        (prep_neg),
        .num_double       (prep_dbl),
        .num_double_minus (prep_dbl_neg),
        .b_ext            (prep_b_ext)
    );

    booth #(
        .DATA_WIDTH (EXT_W),
        .BIAS       (0)
    ) u_booth (
        .y                (mreg_q[2:0]),
        .num_data_width   (num_data_width_q),
        .num_minus        (num_minus_q),
        .num_double       (num_double_q),
        .num_double_minus (num_double_minus_q),
        .pp               (pp)
    );

    carry_save_adder #(
        .DATA_WIDTH (2*XLEN)
    ) u_csa (
        .a     (sum_acc_q),
        .b     (carry_in),
        .c     (pp_shift),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Align the partial product to its digit weight; resolve the final sum
    always_comb begin
        pp_shift = {{(2*XLEN-EXT_W){pp[EXT_W-1]}}, pp} << {cnt_q, 1'b0};
        carry_in = {carry_acc_q[2*XLEN-2:0], 1'b0};
        prod     = sum_acc_q + carry_in;
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    // Next-state and datapath update; flush overrides everything and leaves
    // the datapath registers holding their last values
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        op_d               = op_q;
        mreg_d             = mreg_q;
        num_data_width_d   = num_data_width_q;
        num_minus_d        = num_minus_q;
        num_double_d       = num_double_q;
        num_double_minus_d = num_double_minus_q;
        sum_acc_d          = sum_acc_q;
        carry_acc_d        = carry_acc_q;
        resp_valid_d       = resp_valid_q;
        resp_data_d        = resp_data_q;

        if (bus.flush) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_d               = bus.req_op;
                        num_data_width_d   = prep_pos;
                        num_minus_d        = prep_neg;
                        num_double_d       = prep_dbl;
                        num_double_minus_d = prep_dbl_neg;
                        mreg_d             = {prep_b_ext, 1'b0};
                        sum_acc_d          = '0;
                        carry_acc_d        = '0;
                        cnt_d              = '0;
                        state_d            = CALC;
                    end
                end
                CALC: begin
                    sum_acc_d   = csa_sum;
                    carry_acc_d = csa_carry;
                    mreg_d      = mreg_q >> 2;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    resp_data_d  = (op_q == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            op_q               <= MUL_OP_MUL;
            mreg_q             <= '0;
            num_data_width_q   <= '0;
            num_minus_q        <= '0;
            num_double_q       <= '0;
            num_double_minus_q <= '0;
            sum_acc_q          <= '0;
            carry_acc_q        <= '0;
            resp_valid_q       <= 1'b0;
            resp_data_q        <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            op_q               <= op_d;
            mreg_q             <= mreg_d;
            num_data_width_q   <= num_data_width_d;
            num_minus_q        <= num_minus_d;
            num_double_q       <= num_double_d;
            num_double_minus_q <= num_double_minus_d;
            sum_acc_q          <= sum_acc_d;
            carry_acc_q        <= carry_acc_d;
            resp_valid_q       <= resp_valid_d;
            resp_data_q        <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: fixed vectors, randomized ops
// against a plain-arithmetic product model, and handshake corner cases.
module tb_mul_booth_seq;
    import mul_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mul_booth_seq_if bus ();

    mul_booth_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference product: extend each operand to 64 bits by its signedness,
    // multiply, and select the requested half
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ae;
        logic [63:0] be;
        logic [63:0] p;
        ae = (op == MUL_OP_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
        be = (op == MUL_OP_MUL || op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ae * be;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.req_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    // Issue one request, measure cycles to resp_valid, check data; optionally
    // acknowledge the response
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit ack);
        int lat;
        wait_ready(name);
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd18);
        check({name, "_data"}, 64'(bus.resp_data), 64'(exp));
        if (ack) begin
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit rose;
        rose = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) rose = 1'b1;
        end
        check({name, "_no_resp"}, 64'(rose), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] corners[6];
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp;

        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = MUL_OP_MUL;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.flush     = 1'b0;
        bus.resp_ready = 1'b0;

        vecs.push_back('{"mul_7_m3",    MUL_OP_MUL,    32'h7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{"mul_m1_m1",   MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{"mulhu_m1_m1", MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{"mulh_m1_m1",  MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{"mulhsu_m1_m1", MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{"mulh_min_min", MUL_OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{"mul_shift16", MUL_OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780});
        vecs.push_back('{"mul_3_5",     MUL_OP_MUL,    32'h3,        32'h5,         32'h0000_000F});

        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5555_5555};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset_resp_data", 64'(bus.resp_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
        end

        // Randomized operations against the model, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b1);
        end

        // Backpressure: result held while resp_ready stays low
        exp = model(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        run_op("bp", MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, exp, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", i), 64'(bus.resp_valid), 64'd1);
            check($sformatf("bp_hold_data%0d", i), 64'(bus.resp_data), 64'(exp));
            check($sformatf("bp_hold_ready%0d", i), 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("bp_release_valid", 64'(bus.resp_valid), 64'd0);
        check("bp_release_ready", 64'(bus.req_ready), 64'd1);

        // Flush while in CALC with cnt=8
        wait_ready("flush");
        bus.req_op    = MUL_OP_MUL;
        bus.req_rs1   = 32'h0000_1234;
        bus.req_rs2   = 32'h0000_5678;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_calc_ready", 64'(bus.req_ready), 64'd1);
        check("flush_calc_valid", 64'(bus.resp_valid), 64'd0);
        expect_quiet("flush_calc", 25);
        run_op("after_flush", MUL_OP_MUL, 32'h3, 32'h5, 32'h0000_000F, 1'b1);

        // Reset while holding a result in DONE
        run_op("rst_done", MUL_OP_MUL, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_done_data", 64'(bus.resp_data), 64'd0);
        check("rst_done_ready", 64'(bus.req_ready), 64'd1);

        // flush and req_valid together in IDLE: request dropped
        bus.req_op    = MUL_OP_MUL;
        bus.req_rs1   = 32'h9;
        bus.req_rs2   = 32'h9;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_idle_ready", 64'(bus.req_ready), 64'd1);
        expect_quiet("flush_idle", 25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
